// File: rtl/br_redirect_ctrl_if.sv
// ============================================================================
// Module      : br_redirect_ctrl_if
// Description : EX-side inputs and PC-mux / flush outputs of br_redirect_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface br_redirect_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             ex_valid;
    logic             ex_is_cf;
    logic             ex_br_taken;
    logic [XLEN-1:0]  ex_target;
    logic             stall;

    logic             pc_sel;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             ex_kill;
    logic             misalign_err;
    logic             redirect_busy;
    logic [CNT_W-1:0] br_resolved_cnt;
    logic [CNT_W-1:0] br_taken_cnt;
    logic [CNT_W-1:0] stall_wait_cnt;

    modport master (
        output ex_valid, ex_is_cf, ex_br_taken, ex_target, stall,
        input  pc_sel, redirect_pc, flush_if_id, flush_id_ex, ex_kill,
               misalign_err, redirect_busy,
               br_resolved_cnt, br_taken_cnt, stall_wait_cnt
    );

    modport slave (
        input  ex_valid, ex_is_cf, ex_br_taken, ex_target, stall,
        output pc_sel, redirect_pc, flush_if_id, flush_id_ex, ex_kill,
               misalign_err, redirect_busy,
               br_resolved_cnt, br_taken_cnt, stall_wait_cnt
    );
endinterface

`default_nettype wire

// File: rtl/br_redirect_ctrl.sv
// ============================================================================
// Module      : br_redirect_ctrl
// Description : Taken-branch PC redirect / wrong-path squash sequencer.
//               Optional statistics counters enabled by macro BR_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module br_redirect_ctrl #(
    parameter int XLEN       = 32,
    parameter int ALIGN_BITS = 2,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    br_redirect_ctrl_if.slave  bus
);
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_pend  = 2'd1;
    localparam logic [1:0] c_st_redir = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_misalign_err;
    logic            w_resolve;
    logic            w_misaligned;
    logic            w_take;

    assign w_resolve    = bus.ex_valid & bus.ex_is_cf & bus.ex_br_taken;
    assign w_misaligned = |bus.ex_target[ALIGN_BITS-1:0];
    // Only an IDLE-state resolve is on the correct path; anything else is squashed.
    assign w_take       = (r_state == c_st_idle) & w_resolve & ~w_misaligned;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_take) begin
                    w_state_nxt = bus.stall ? c_st_pend : c_st_redir;
                end
            end
            c_st_pend: begin
                if (!bus.stall) begin
                    w_state_nxt = c_st_redir;
                end
            end
            c_st_redir: begin
                if (!bus.stall) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_redirect_pc  <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_misalign_err <= (r_state == c_st_idle) & w_resolve & w_misaligned;
            if (w_take) begin
                r_redirect_pc <= bus.ex_target;
            end
        end
    end

    assign bus.pc_sel        = (r_state == c_st_redir);
    assign bus.flush_if_id   = (r_state == c_st_redir);
    assign bus.flush_id_ex   = (r_state == c_st_redir);
    assign bus.ex_kill       = (r_state == c_st_redir);
    assign bus.redirect_busy = (r_state != c_st_idle);
    assign bus.redirect_pc   = r_redirect_pc;
    assign bus.misalign_err  = r_misalign_err;

`ifdef BR_STATS_EN
    logic [CNT_W-1:0] r_resolved_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_inc_resolved;
    logic             w_inc_taken;
    logic             w_inc_wait;

    assign w_inc_resolved = (r_state == c_st_idle) & bus.ex_valid & bus.ex_is_cf & ~bus.stall;
    assign w_inc_taken    = (w_state_nxt == c_st_redir) & (r_state != c_st_redir);
    assign w_inc_wait     = (r_state == c_st_pend);

    // Saturating: counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resolved_cnt <= '0;
            r_taken_cnt    <= '0;
            r_wait_cnt     <= '0;
        end else begin
            if (w_inc_resolved && (r_resolved_cnt != {CNT_W{1'b1}})) begin
                r_resolved_cnt <= r_resolved_cnt + 1'b1;
            end
            if (w_inc_taken && (r_taken_cnt != {CNT_W{1'b1}})) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
            if (w_inc_wait && (r_wait_cnt != {CNT_W{1'b1}})) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign bus.br_resolved_cnt = r_resolved_cnt;
    assign bus.br_taken_cnt    = r_taken_cnt;
    assign bus.stall_wait_cnt  = r_wait_cnt;
`else
    assign bus.br_resolved_cnt = {CNT_W{1'b0}};
    assign bus.br_taken_cnt    = {CNT_W{1'b0}};
    assign bus.stall_wait_cnt  = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_br_redirect_ctrl.sv
// ============================================================================
// Module      : tb_br_redirect_ctrl
// Description : Directed-vector scoreboard bench for br_redirect_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_br_redirect_ctrl;
`ifdef BR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic        ps;
        logic [31:0] rpc;
        logic        mis;
        logic        busy;
        logic [31:0] rc;
        logic [31:0] tc;
        logic [31:0] wc;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t q[$];

    br_redirect_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();

    br_redirect_ctrl #(
        .XLEN       (32),
        .ALIGN_BITS (2),
        .CNT_W      (32)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of EX inputs and queue the outputs expected after the edge.
    task automatic row(input logic v, input logic cf, input logic tk, input logic [31:0] tgt,
                       input logic st, input logic ps, input logic [31:0] rpc, input logic mis,
                       input logic busy, input int rc, input int tc, input int wc);
        exp_t e;
        bus.ex_valid    = v;
        bus.ex_is_cf    = cf;
        bus.ex_br_taken = tk;
        bus.ex_target   = tgt;
        bus.stall       = st;
        @(posedge clk);
        e.ps = ps; e.rpc = rpc; e.mis = mis; e.busy = busy;
        e.rc = rc; e.tc = tc; e.wc = wc;
        q.push_back(e);
        #1;
    endtask

    // Monitor: compares the DUT state presented after each edge against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_sel",        {31'd0, bus.pc_sel},        {31'd0, e.ps});
                chk("flush_if_id",   {31'd0, bus.flush_if_id},   {31'd0, e.ps});
                chk("flush_id_ex",   {31'd0, bus.flush_id_ex},   {31'd0, e.ps});
                chk("ex_kill",       {31'd0, bus.ex_kill},       {31'd0, e.ps});
                chk("redirect_pc",   bus.redirect_pc,            e.rpc);
                chk("misalign_err",  {31'd0, bus.misalign_err},  {31'd0, e.mis});
                chk("redirect_busy", {31'd0, bus.redirect_busy}, {31'd0, e.busy});
                chk("resolved_cnt",  bus.br_resolved_cnt,        STATS ? e.rc : 32'd0);
                chk("taken_cnt",     bus.br_taken_cnt,           STATS ? e.tc : 32'd0);
                chk("wait_cnt",      bus.stall_wait_cnt,         STATS ? e.wc : 32'd0);
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc_sel"}, {31'd0, bus.pc_sel}, 32'd0);
        chk({tag, "_flush_if_id"}, {31'd0, bus.flush_if_id}, 32'd0);
        chk({tag, "_flush_id_ex"}, {31'd0, bus.flush_id_ex}, 32'd0);
        chk({tag, "_ex_kill"}, {31'd0, bus.ex_kill}, 32'd0);
        chk({tag, "_misalign"}, {31'd0, bus.misalign_err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.redirect_busy}, 32'd0);
        chk({tag, "_redirect_pc"}, bus.redirect_pc, 32'd0);
        chk({tag, "_resolved_cnt"}, bus.br_resolved_cnt, 32'd0);
        chk({tag, "_taken_cnt"}, bus.br_taken_cnt, 32'd0);
        chk({tag, "_wait_cnt"}, bus.stall_wait_cnt, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.ex_valid = 1'b0; bus.ex_is_cf = 1'b0; bus.ex_br_taken = 1'b0;
        bus.ex_target = 32'd0; bus.stall = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;

        //   v  cf tk target        st  ps rpc           mis busy rc tc wc
        row(0, 0, 0, 32'h0000_0000, 0,  0, 32'h0000_0000, 0, 0,   0, 0, 0);
        row(1, 1, 1, 32'h0000_0100, 0,  1, 32'h0000_0100, 0, 1,   1, 1, 0); // taken BEQ
        row(0, 0, 0, 32'h0000_0000, 0,  0, 32'h0000_0100, 0, 0,   1, 1, 0);
        row(1, 1, 0, 32'h0000_0180, 0,  0, 32'h0000_0100, 0, 0,   2, 1, 0); // not-taken BNE
        row(1, 0, 1, 32'h0000_0400, 0,  0, 32'h0000_0100, 0, 0,   2, 1, 0); // non-CF
        row(1, 1, 1, 32'h0000_0200, 1,  0, 32'h0000_0200, 0, 1,   2, 1, 0); // JAL under stall
        row(1, 1, 1, 32'h0000_0500, 1,  0, 32'h0000_0200, 0, 1,   2, 1, 1);
        row(0, 0, 0, 32'h0000_0000, 1,  0, 32'h0000_0200, 0, 1,   2, 1, 2);
        row(0, 0, 0, 32'h0000_0000, 1,  0, 32'h0000_0200, 0, 1,   2, 1, 3);
        row(0, 0, 0, 32'h0000_0000, 0,  1, 32'h0000_0200, 0, 1,   2, 2, 4); // stall drops
        row(0, 0, 0, 32'h0000_0000, 0,  0, 32'h0000_0200, 0, 0,   2, 2, 4);
        row(1, 1, 1, 32'h0000_0102, 0,  0, 32'h0000_0200, 1, 0,   3, 2, 4); // misaligned
        row(0, 0, 0, 32'h0000_0000, 0,  0, 32'h0000_0200, 0, 0,   3, 2, 4);
        row(1, 1, 1, 32'h0000_0100, 0,  1, 32'h0000_0100, 0, 1,   4, 3, 4);
        row(1, 1, 1, 32'h0000_0300, 0,  0, 32'h0000_0100, 0, 0,   4, 3, 4); // wrong-path
        row(0, 0, 0, 32'h0000_0000, 0,  0, 32'h0000_0100, 0, 0,   4, 3, 4);
        row(1, 1, 1, 32'h0000_0040, 0,  1, 32'h0000_0040, 0, 1,   5, 4, 4);
        row(1, 1, 1, 32'h0000_0300, 1,  1, 32'h0000_0040, 0, 1,   5, 4, 4); // REDIRECT held
        row(0, 0, 0, 32'h0000_0000, 0,  0, 32'h0000_0040, 0, 0,   5, 4, 4);
        row(1, 1, 1, 32'h0000_0200, 1,  0, 32'h0000_0200, 0, 1,   5, 4, 4);
        row(0, 0, 0, 32'h0000_0000, 1,  0, 32'h0000_0200, 0, 1,   5, 4, 5);

        // Asynchronous reset between edges while PENDING.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        row(0, 0, 0, 32'h0000_0000, 1,  0, 32'h0000_0000, 0, 0,   0, 0, 0);
        row(0, 0, 0, 32'h0000_0000, 0,  0, 32'h0000_0000, 0, 0,   0, 0, 0);
        row(0, 0, 0, 32'h0000_0000, 0,  0, 32'h0000_0000, 0, 0,   0, 0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            chk("scoreboard_drain", q.size(), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/br_redirect_ctrl.md
Name: br_redirect_ctrl

Overview:
Control-flow redirect sequencer for the 5-stage pipeline. It takes the execute-stage taken/not-taken decision from the branch comparator plus the computed target, and sequences the PC redirect and wrong-path squash. It holds a pending redirect while the pipeline is stalled by the LSU/UART path. It sits between EX, the PC mux and the IF/ID and ID/EX pipeline-register flush inputs.

Parameters:
XLEN, 32, PC and target width
ALIGN_BITS, 2, low target bits that must be zero (1 if compressed support is ever added)
CNT_W, 32, width of statistics counters (used only with BR_STATS_EN)

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous active-high reset
ex_valid  input  1  EX stage holds a live instruction
ex_is_cf  input  1  EX instruction is B-type, JAL or JALR
ex_br_taken  input  1  taken decision from branch comparator (already 1 for JAL)
ex_target  input  XLEN  computed branch/jump target
stall  input  1  global pipeline stall (LSU/UART busy); pipeline registers hold while high
pc_sel  output  1  1 = PC loads redirect_pc next edge
redirect_pc  output  XLEN  registered redirect target
flush_if_id  output  1  bubble into IF/ID on next advancing edge
flush_id_ex  output  1  bubble into ID/EX on next advancing edge
ex_kill  output  1  current EX instruction is wrong-path; suppress its writeback/memory op
misalign_err  output  1  one-cycle pulse, taken target misaligned
redirect_busy  output  1  state != IDLE
br_resolved_cnt  output  CNT_W  control-flow instructions resolved
br_taken_cnt  output  CNT_W  taken redirects issued
stall_wait_cnt  output  CNT_W  cycles spent in PENDING

Behaviour:
- Reset (async, rst=1): state=IDLE, redirect_pc=0; all outputs 0; counters 0. A reset mid-PENDING or mid-REDIRECT discards the latched target.
- resolve = ex_valid & ex_is_cf & ex_br_taken, evaluated only in IDLE.
- IDLE:
  - resolve & (ex_target[ALIGN_BITS-1:0] != 0): misalign_err=1 next cycle, no redirect, stay IDLE.
  - resolve & aligned & !stall: latch redirect_pc <= ex_target, go REDIRECT.
  - resolve & aligned & stall: latch target, go PENDING.
- PENDING: all redirect outputs 0; EX inputs ignored. When stall=0, go REDIRECT (the branch advances out of EX on this edge).
- REDIRECT: pc_sel=1, flush_if_id=1, flush_id_ex=1, ex_kill=1, all combinational from state.
  - If stall=0: return to IDLE next edge.
  - If stall=1: remain in REDIRECT with outputs held and redirect_pc stable.
  - Any resolve seen in REDIRECT is wrong-path and is ignored.
- Latency/penalty: taken branch in EX at cycle N (no stall) gives pc_sel at N+1 and the correct-path fetch at N+2. Penalty is 3 bubbles.
- Not-taken, or ex_is_cf=0: no action, 0-cycle penalty.
- redirect_busy=1 in PENDING and REDIRECT.
- Outputs other than the REDIRECT decodes come straight from flops. No combinational path from ex_* to pc_sel.

Optional Feature:
BR_STATS_EN:
- Defined: CNT_W saturating counters, cleared by rst.
  - br_resolved_cnt increments on every IDLE-state ex_valid & ex_is_cf with !stall.
  - br_taken_cnt increments on entry to REDIRECT.
  - stall_wait_cnt increments each cycle in PENDING.
  - Counters stick at all-ones.
- Undefined: the three count ports are tied to 0 and no counter flops exist. Ports remain present.

Test Plan:
- Taken BEQ, ex_target=0x0000_0100, stall=0 at cycle 5 -> cycle 6: pc_sel=1, redirect_pc=0x100, flush_if_id=flush_id_ex=ex_kill=1. Cycle 7: all 0, state IDLE.
- Not-taken BNE (ex_br_taken=0) -> pc_sel, flushes and ex_kill stay 0 for all cycles; br_resolved_cnt +1, br_taken_cnt unchanged (with BR_STATS_EN).
- Taken JAL to 0x200 with stall=1 for 4 cycles -> PENDING for 4 cycles (stall_wait_cnt=4) with no flush. The cycle after stall drops gives REDIRECT with redirect_pc=0x200.
- Taken branch to 0x0000_0102 -> misalign_err pulses 1 cycle; pc_sel never asserts; state IDLE.
- Second taken branch (target 0x300) present in EX during REDIRECT for 0x100 -> ignored; redirect_pc stays 0x100; no second REDIRECT.
- rst asserted asynchronously mid-PENDING -> same instant: all outputs 0, redirect_pc=0. After release, stall drop causes no redirect.
